// File: rtl/add_seq.sv
// add_seq: multi-cycle W-bit adder, two operand bits per clock through a single
// add2b slice, LSB pair first, with a start/busy/done handshake.
`default_nettype none

module fac (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module add2b (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);
  logic c1;

  fac u_fa0 (.a(a[0]), .b(b[0]), .ci(ci), .s(s[0]), .co(c1));
  fac u_fa1 (.a(a[1]), .b(b[1]), .ci(c1), .s(s[1]), .co(co));
endmodule

module add_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         co
);
  localparam int N  = W / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic           load, step, last;
  logic [W-1:0]   a_reg, b_reg, s_reg, s_nxt;
  logic           c_reg;
  logic [CW-1:0]  cnt;
  logic [1:0]     slice_s;
  logic           slice_co;

  add2b u_slice (
    .a  (a_reg[1:0]),
    .b  (b_reg[1:0]),
    .ci (c_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  // New slice sum enters at the top; after N steps S holds the full sum in place.
  generate
    if (W == 2) begin : g_narrow
      assign s_nxt = slice_s;
    end else begin : g_wide
      assign s_nxt = {slice_s, s_reg[W-1:2]};
    end
  endgenerate

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      z     <= '0;
      co    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_reg <= x;
        b_reg <= y;
        c_reg <= ci;
        s_reg <= '0;
        cnt   <= '0;
      end else if (step) begin
        a_reg <= a_reg >> 2;
        b_reg <= b_reg >> 2;
        c_reg <= slice_co;
        s_reg <= s_nxt;
        cnt   <= cnt + CW'(1);
        if (last) begin
          z    <= s_nxt;
          co   <= slice_co;
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

`default_nettype wire
